seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Multicycle restoring divider; the inverse operator of the PE's Wallace-tree multiplier.
//  Computes quotient = dividend / divisor and remainder = dividend % divisor, one quotient bit per cycle.
//  Sits beside the PE datapath for normalisation/rescaling of accumulated psums.
//  Valid/ready handshake on both sides; one operation in flight at a time.
// PARAMETERS
//  DIVIDEND_WIDTH  8  dividend and quotient width; also the iteration count
//  DIVISOR_WIDTH   4  divisor and remainder width
// PORTS
//  clk            in   1               clock, rising edge
//  reset          in   1               asynchronous, active-high reset
//  in_valid       in   1               dividend/divisor valid
//  in_ready       out  1               divider can accept an operation
//  dividend       in   DIVIDEND_WIDTH  numerator
//  divisor        in   DIVISOR_WIDTH   denominator
//  out_valid      out  1               result valid
//  out_ready      in   1               consumer accepts the result
//  quotient       out  DIVIDEND_WIDTH  dividend / divisor
//  remainder      out  DIVISOR_WIDTH   dividend % divisor
//  div_by_zero    out  1               divisor was zero for this result
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0; counter cleared.
//  Reset asserted mid-operation aborts it; no result is produced and the operands are discarded.
//  FSM:
//  - IDLE: in_ready=1. Accept on in_valid&in_ready; latch operands.
//    divisor==0 -> DONE next cycle; otherwise -> CALC with count=0.
//  - CALC: in_ready=0. Each cycle: partial={partial[DIVISOR_WIDTH-1:0],dq[MSB]}; dq<<=1.
//    If partial>=divisor then partial-=divisor and dq[0]=1.
//    Partial remainder is DIVISOR_WIDTH+1 bits wide; no overflow is possible.
//    After DIVIDEND_WIDTH iterations (count==DIVIDEND_WIDTH-1) -> DONE.
//  - DONE: out_valid=1; outputs are stable and held until out_valid&out_ready.
//    On that handshake -> IDLE. in_ready=0 in DONE; no new operation is accepted in the same cycle.
//  Latency: accept edge T -> out_valid high after edge T+DIVIDEND_WIDTH+1.
//  Divide-by-zero: out_valid after edge T+1. quotient={DIVIDEND_WIDTH{1'b1}}, remainder=0, div_by_zero=1.
//  div_by_zero=0 for every other result.
//  Back-pressure: out_ready low holds DONE indefinitely; outputs do not change.
//  in_valid is ignored while not in IDLE; operands need only be valid on the accept cycle.
//  quotient, remainder and div_by_zero are registered; they change only on DONE entry or reset.
// CONFIGURATION
//  DIV_SIGNED_EN defined:
//  - Operands and results are two's complement.
//  - Magnitudes are divided unsigned.
//  - Quotient is negated when the operand signs differ; it truncates toward zero.
//  - Remainder takes the sign of the dividend.
//  - Sign fix-up is applied when DONE is loaded; latency is unchanged.
//  - Most-negative dividend / -1 wraps: quotient=most-negative, remainder=0.
//  - Divide-by-zero behaves as in unsigned mode.
//  DIV_SIGNED_EN undefined: all operands and results are unsigned; no sign logic is built.
// TESTING (defaults 8/4)
//  200/7 -> quotient=28, remainder=4, div_by_zero=0; out_valid exactly 9 cycles after accept.
//  15/0 -> quotient=255, remainder=0, div_by_zero=1; out_valid 1 cycle after accept.
//  255/1 and 5/9 -> 255 r0 and 0 r5; back-to-back ops with out_ready=1 show one idle cycle between.
//  Back-pressure: result 100/3 (33 r1), out_ready low for 20 cycles.
//  -> outputs held, in_ready=0, new in_valid ignored until release.
//  Reset pulsed 4 cycles into CALC -> out_valid stays 0.
//  -> next op 81/9 returns 9 r0.
//  DIV_SIGNED_EN: -100/7 -> -14 r-2; 100/-7 -> -14 r2; -128/-1 -> -128 r0.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: multicycle restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Optional build macro DIV_SIGNED_EN: two's-complement operands/results (magnitude divide + sign fix-up).
module seq_divider #(
  parameter int DIVIDEND_WIDTH = 8,
  parameter int DIVISOR_WIDTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero
);
  // state  | meaning
  // S_IDLE | waiting for an operation, in_ready high
  // S_CALC | one restoring iteration per cycle
  // S_LOAD | result registers (and sign fix-up) are loaded on leaving this state
  // S_DONE | result valid, held until out_ready
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_LOAD, S_DONE} state_t;

  localparam int CW = (DIVIDEND_WIDTH > 1) ? $clog2(DIVIDEND_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVIDEND_WIDTH - 1);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [DIVIDEND_WIDTH-1:0] r_dq;
  logic [DIVISOR_WIDTH-1:0]  r_part;
  logic [DIVISOR_WIDTH-1:0]  r_dvs;
  logic [CW-1:0]             r_count;
  logic [DIVIDEND_WIDTH-1:0] r_quot;
  logic [DIVISOR_WIDTH-1:0]  r_rem;
  logic                      r_dbz;
  logic [DIVIDEND_WIDTH-1:0] w_mag_a;
  logic [DIVISOR_WIDTH-1:0]  w_mag_b;
  logic [DIVISOR_WIDTH:0]    w_diff;
  logic                      w_ge;
`ifdef DIV_SIGNED_EN
  logic                      r_neg_q;
  logic                      r_neg_r;
`endif

  always_comb begin
    w_mag_a = dividend;
    w_mag_b = divisor;
`ifdef DIV_SIGNED_EN
    if (dividend[DIVIDEND_WIDTH-1]) w_mag_a = -dividend;
    if (divisor[DIVISOR_WIDTH-1])   w_mag_b = -divisor;
`endif
  end

  // Partial remainder stays below the divisor, so the borrow bit alone decides restore vs subtract.
  assign w_diff = {r_part, r_dq[DIVIDEND_WIDTH-1]} - {1'b0, r_dvs};
  assign w_ge   = ~w_diff[DIVISOR_WIDTH];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = (divisor == '0) ? S_LOAD : S_CALC;
      S_CALC:  if (r_count == LAST) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dq    <= '0;
      r_part  <= '0;
      r_dvs   <= '0;
      r_count <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_dq    <= w_mag_a;
            r_dvs   <= w_mag_b;
            r_part  <= '0;
            r_count <= '0;
`ifdef DIV_SIGNED_EN
            r_neg_q <= dividend[DIVIDEND_WIDTH-1] ^ divisor[DIVISOR_WIDTH-1];
            r_neg_r <= dividend[DIVIDEND_WIDTH-1];
`endif
          end
        end
        S_CALC: begin
          r_part  <= w_ge ? w_diff[DIVISOR_WIDTH-1:0] : {r_part[DIVISOR_WIDTH-2:0], r_dq[DIVIDEND_WIDTH-1]};
          r_dq    <= {r_dq[DIVIDEND_WIDTH-2:0], w_ge};
          r_count <= r_count + CW'(1);
        end
        S_LOAD: begin
          if (r_dvs == '0) begin
            r_quot <= '1;
            r_rem  <= '0;
            r_dbz  <= 1'b1;
          end else begin
            r_quot <= r_dq;
            r_rem  <= r_part;
            r_dbz  <= 1'b0;
`ifdef DIV_SIGNED_EN
            if (r_neg_q) r_quot <= -r_dq;
            if (r_neg_r) r_rem  <= -r_part;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random divisions checked against an arithmetic reference model.
// Also exercises latency, back-pressure, mid-operation reset and the DIV_SIGNED_EN build.
module tb_seq_divider;
  localparam int DW = 8;
  localparam int VW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_divider #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [DW-1:0] a, input logic [VW-1:0] b,
                                output logic [DW-1:0] q, output logic [VW-1:0] r, output logic z);
`ifdef DIV_SIGNED_EN
    int sa;
    int sb;
`endif
    if (b == '0) begin
      q = '1; r = '0; z = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      sa = $signed(a);
      sb = $signed(b);
      q = DW'(sa / sb);
      r = VW'(sa % sb);
`else
      q = a / b;
      r = a % b;
`endif
      z = 1'b0;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [DW-1:0] a, input logic [VW-1:0] b, input int hold);
    logic [DW-1:0] eq;
    logic [VW-1:0] er;
    logic          ez;
    int            n;
    int            lat;
    model(a, b, eq, er, ez);
    n = 0;
    while (!in_ready && n < 30) begin step(); n++; end
    chk("in_ready", in_ready, 1);
    dividend = a; divisor = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    dividend = DW'($urandom); divisor = VW'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin step(); lat++; end
    chk("latency", lat, (b == '0) ? 1 : DW + 1);
    chk("result", {quotient, remainder, div_by_zero}, {eq, er, ez});
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      dividend = DW'($urandom); divisor = VW'($urandom);
      step();
      chk("hold", {out_valid, in_ready, quotient, remainder, div_by_zero}, {2'b10, eq, er, ez});
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("idle_after", {out_valid, in_ready}, 2'b01);
    chk("result_kept", {quotient, remainder, div_by_zero}, {eq, er, ez});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    repeat (3) step();
    chk("rst_state", {in_ready, out_valid, quotient, remainder, div_by_zero}, {2'b10, 8'h00, 4'h0, 1'b0});
    reset = 1'b0;
    step();
    chk("post_rst", {in_ready, out_valid}, 2'b10);

    do_op(8'd200, 4'd7, 0);
    do_op(8'd15,  4'd0, 0);
    do_op(8'd255, 4'd1, 0);
    do_op(8'd5,   4'd9, 0);
    do_op(8'd100, 4'd3, 20);
`ifdef DIV_SIGNED_EN
    do_op(8'h9C, 4'h7, 1);
    do_op(8'h64, 4'h9, 1);
    do_op(8'h80, 4'hF, 1);
    do_op(8'h80, 4'h1, 0);
    do_op(8'h80, 4'h8, 0);
`endif

    // Abort a division in flight and confirm nothing emerges.
    dividend = 8'd200; divisor = 4'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    #2;
    chk("rst_async", {in_ready, out_valid, quotient, remainder, div_by_zero}, {2'b10, 8'h00, 4'h0, 1'b0});
    step();
    reset = 1'b0;
    bad = 0;
    repeat (15) begin step(); if (out_valid) bad++; end
    chk("rst_abort", bad, 0);
    chk("rst_outputs", {in_ready, quotient, remainder, div_by_zero}, {1'b1, 8'h00, 4'h0, 1'b0});
    do_op(8'd81, 4'd9, 0);

    for (int k = 0; k < 40; k++) begin
      logic [DW-1:0] ra;
      logic [VW-1:0] rb;
      ra = DW'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? VW'(0) : VW'($urandom);
      do_op(ra, rb, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
